// File: rtl/osc_spi_pkg.sv
// Shared types and constants for the oscilloscope SPI path: arbiter states
// and slave-select encodings.
package osc_spi_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    BUSY   = 2'd2,
    GAP    = 2'd3
  } arb_state_t;

  localparam logic [2:0] SS_NONE = 3'b111;
  localparam logic [2:0] SS_EEP  = 3'b100;
  localparam logic [2:0] SS_AFE0 = 3'b000;
  localparam logic [2:0] SS_AFE1 = 3'b001;
  localparam logic [2:0] SS_AFE2 = 3'b010;

endpackage

// File: rtl/spi_arbiter_if.sv
// Bundles the two requester ports and the SPI-master side of the arbiter.
// slave = arbiter view; master = environment (requesters + SPI master).
interface spi_arbiter_if;

  logic        req0;
  logic [2:0]  ss0;
  logic [15:0] data0;
  logic        req1;
  logic [2:0]  ss1;
  logic [15:0] data1;
  logic        done0;
  logic        done1;
  logic [15:0] rd_data;
  logic        err;
  logic        wrt_SPI;
  logic [15:0] SPI_data;
  logic [2:0]  ss;
  logic        SPI_done;
  logic [15:0] SPI_rd;

  modport slave (
    input  req0, ss0, data0, req1, ss1, data1, SPI_done, SPI_rd,
    output done0, done1, rd_data, err, wrt_SPI, SPI_data, ss
  );

  modport master (
    output req0, ss0, data0, req1, ss1, data1, SPI_done, SPI_rd,
    input  done0, done1, rd_data, err, wrt_SPI, SPI_data, ss
  );

endinterface

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: a lone request wins outright, a tie goes to
// the requester that was not granted last.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last_gnt,
  output logic gnt_valid,
  output logic gnt
);

  assign gnt_valid = req0 | req1;
  assign gnt       = (req0 & req1) ? ~last_gnt : req1;

endmodule

// File: rtl/spi_arbiter.sv
// Shares one SPI master between two requesters: round-robin grant, launch,
// wait for SPI_done or timeout, return read data, then hold a select gap.
module spi_arbiter
  import osc_spi_pkg::*;
#(
  parameter int TIMEOUT = 4096,
  parameter int GAP_CYC = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  spi_arbiter_if.slave   bus
);

  localparam int TW = $clog2(TIMEOUT);
  localparam int GW = $clog2(GAP_CYC + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] G_LAST = GW'(GAP_CYC - 1);

  arb_state_t    state_reg, state_next;
  logic          gnt_reg, gnt_next;
  logic          last_gnt_reg, last_gnt_next;
  logic [2:0]    ss_reg, ss_next;
  logic [15:0]   spi_data_reg, spi_data_next;
  logic [15:0]   rd_data_reg, rd_data_next;
  logic          err_reg, err_next;
  logic          done0_reg, done0_next;
  logic          done1_reg, done1_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic [GW-1:0] gap_reg, gap_next;

  logic pick_valid;
  logic pick_gnt;

  rr_pick2 u_pick (
    .req0      (bus.req0),
    .req1      (bus.req1),
    .last_gnt  (last_gnt_reg),
    .gnt_valid (pick_valid),
    .gnt       (pick_gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      gnt_reg      <= 1'b0;
      last_gnt_reg <= 1'b1;  // requester 0 wins the first tie
      ss_reg       <= SS_NONE;
      spi_data_reg <= '0;
      rd_data_reg  <= '0;
      err_reg      <= 1'b0;
      done0_reg    <= 1'b0;
      done1_reg    <= 1'b0;
      timer_reg    <= '0;
      gap_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      gnt_reg      <= gnt_next;
      last_gnt_reg <= last_gnt_next;
      ss_reg       <= ss_next;
      spi_data_reg <= spi_data_next;
      rd_data_reg  <= rd_data_next;
      err_reg      <= err_next;
      done0_reg    <= done0_next;
      done1_reg    <= done1_next;
      timer_reg    <= timer_next;
      gap_reg      <= gap_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    gnt_next      = gnt_reg;
    last_gnt_next = last_gnt_reg;
    ss_next       = ss_reg;
    spi_data_next = spi_data_reg;
    rd_data_next  = rd_data_reg;
    err_next      = err_reg;
    done0_next    = 1'b0;
    done1_next    = 1'b0;
    timer_next    = timer_reg;
    gap_next      = gap_reg;

    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          gnt_next      = pick_gnt;
          ss_next       = pick_gnt ? bus.ss1 : bus.ss0;
          spi_data_next = pick_gnt ? bus.data1 : bus.data0;
          state_next    = LAUNCH;
        end
      end
      LAUNCH: begin
        timer_next = '0;
        state_next = BUSY;
      end
      BUSY: begin
        // SPI_done takes priority over a simultaneous timeout
        if (bus.SPI_done || (timer_reg == T_LAST)) begin
          if (bus.SPI_done) begin
            rd_data_next = bus.SPI_rd;
            err_next     = 1'b0;
          end else begin
            err_next     = 1'b1;
          end
          done0_next    = ~gnt_reg;
          done1_next    = gnt_reg;
          last_gnt_next = gnt_reg;
          ss_next       = SS_NONE;
          gap_next      = '0;
          state_next    = GAP;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      GAP: begin
        if (gap_reg == G_LAST) begin
          state_next = IDLE;
        end else begin
          gap_next = gap_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.wrt_SPI  = (state_reg == LAUNCH);
  assign bus.ss       = ss_reg;
  assign bus.SPI_data = spi_data_reg;
  assign bus.rd_data  = rd_data_reg;
  assign bus.err      = err_reg;
  assign bus.done0    = done0_reg;
  assign bus.done1    = done1_reg;

endmodule

// File: tb/tb_spi_arbiter.sv
// Scoreboard bench for spi_arbiter: stimulus queues expected launches and
// completions, a monitor checks them as the DUT presents wrt_SPI / done.
module tb_spi_arbiter;
  import osc_spi_pkg::*;

  localparam int TIMEOUT = 16;
  localparam int GAP_CYC = 4;

  logic clk;
  logic rst_n;
  int   cyc;

  spi_arbiter_if bus();

  spi_arbiter #(.TIMEOUT(TIMEOUT), .GAP_CYC(GAP_CYC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [2:0] ss; logic [15:0] data; } launch_t;
  typedef struct { bit owner; logic [15:0] rd; bit err; int lat; } done_t;
  typedef struct { bit respond; int delay; logic [15:0] rd; } spi_t;

  launch_t launch_q[$];
  done_t   done_q[$];
  spi_t    spi_q[$];

  int n_checks;
  int n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_event(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event occurred, expected none (cycle %0d)", name, cyc);
  endtask

  // Queue one transaction: what the DUT should launch, how the SPI master
  // model answers, and what completion the requester should see.
  task automatic expect_txn(input bit owner, input logic [2:0] s, input logic [15:0] dt,
                            input bit respond, input int delay, input logic [15:0] resp,
                            input logic [15:0] exp_rd, input bit exp_err);
    int lat;
    lat = (respond && delay <= TIMEOUT) ? delay + 1 : TIMEOUT + 1;
    launch_q.push_back(launch_t'{s, dt});
    spi_q.push_back(spi_t'{respond, delay, resp});
    done_q.push_back(done_t'{owner, exp_rd, exp_err, lat});
  endtask

  task automatic wait_done(input bit owner, input bit drop);
    int n;
    for (n = 0; n < 300; n++) begin
      @(negedge clk);
      if (owner ? bus.done1 : bus.done0) break;
    end
    if (n == 300) begin
      n_checks++;
      n_fail++;
      $display("FAIL done%0d_wait: no done pulse within 300 cycles, expected one", owner);
    end else if (drop) begin
      if (owner) bus.req1 = 1'b0;
      else       bus.req0 = 1'b0;
    end
  endtask

  task automatic wait_wrt();
    int n;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus.wrt_SPI) break;
    end
    if (n == 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL wrt_wait: no wrt_SPI within 100 cycles, expected one");
    end
  endtask

  // SPI master model: answers each wrt_SPI per the queued response
  initial begin
    bit   pend;
    int   cnt;
    spi_t s;
    pend = 1'b0;
    cnt  = 0;
    s    = spi_t'{1'b1, 5, 16'hDEAD};
    bus.SPI_done = 1'b0;
    bus.SPI_rd   = 16'h5A5A;
    forever begin
      @(negedge clk);
      bus.SPI_done = 1'b0;
      bus.SPI_rd   = 16'h5A5A;
      if (!rst_n) begin
        pend = 1'b0;
      end else if (bus.wrt_SPI) begin
        if (spi_q.size() > 0) s = spi_q.pop_front();
        else                  s = spi_t'{1'b1, 5, 16'hDEAD};
        pend = s.respond;
        cnt  = s.delay;
      end else if (pend) begin
        cnt--;
        if (cnt <= 0) begin
          bus.SPI_done = 1'b1;
          bus.SPI_rd   = s.rd;
          pend         = 1'b0;
        end
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    launch_t    l;
    done_t      d;
    int         launch_cyc;
    int         last_done;
    int         gap_left;
    bit         in_txn;
    logic [2:0] cur_ss;
    logic [15:0] cur_data;
    launch_cyc = 0; last_done = -1; gap_left = 0; in_txn = 1'b0;
    cur_ss = SS_NONE; cur_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_txn    = 1'b0;
        last_done = -1;
        gap_left  = 0;
      end else begin
        if (gap_left > 0) begin
          check("gap_ss", bus.ss, SS_NONE);
          check("gap_wrt", bus.wrt_SPI, 1'b0);
          gap_left--;
        end
        if (bus.wrt_SPI) begin
          if (launch_q.size() == 0) begin
            fail_event("unexpected_launch");
          end else begin
            l = launch_q.pop_front();
            check("launch_ss", bus.ss, l.ss);
            check("launch_data", bus.SPI_data, l.data);
            if (last_done >= 0)
              check("grant_spacing_ok", (cyc - last_done) >= GAP_CYC + 1, 1'b1);
          end
          in_txn     = 1'b1;
          launch_cyc = cyc;
          cur_ss     = bus.ss;
          cur_data   = bus.SPI_data;
          $display("cycle %0d: launch ss=%03b data=%04h", cyc, bus.ss, bus.SPI_data);
        end else if (in_txn && !(bus.done0 || bus.done1)) begin
          check("busy_ss", bus.ss, cur_ss);
          check("busy_data", bus.SPI_data, cur_data);
        end
        if (bus.done0 || bus.done1) begin
          if (bus.done0 && bus.done1) fail_event("both_done");
          if (done_q.size() == 0) begin
            fail_event("unexpected_done");
          end else begin
            d = done_q.pop_front();
            check("done_owner", bus.done1, d.owner);
            check("done_rd_data", bus.rd_data, d.rd);
            check("done_err", bus.err, d.err);
            check("done_latency", cyc - launch_cyc, d.lat);
            check("done_ss_idle", bus.ss, SS_NONE);
            check("done_data_held", bus.SPI_data, cur_data);
          end
          $display("cycle %0d: done%0d rd_data=%04h err=%0b", cyc, bus.done1, bus.rd_data, bus.err);
          in_txn    = 1'b0;
          last_done = cyc;
          gap_left  = GAP_CYC - 1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    bus.req0 = 1'b0; bus.ss0 = 3'b000; bus.data0 = '0;
    bus.req1 = 1'b0; bus.ss1 = 3'b000; bus.data1 = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ss", bus.ss, SS_NONE);
    check("rst_spi_data", bus.SPI_data, 16'h0000);
    check("rst_rd_data", bus.rd_data, 16'h0000);
    check("rst_err", bus.err, 1'b0);
    check("rst_wrt", bus.wrt_SPI, 1'b0);
    check("rst_done0", bus.done0, 1'b0);
    check("rst_done1", bus.done1, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_ss", bus.ss, SS_NONE);
    check("idle_wrt", bus.wrt_SPI, 1'b0);

    // Simultaneous pair after reset: requester 0 first
    expect_txn(1'b0, SS_AFE1, 16'h2001, 1'b1, 6, 16'h1111, 16'h1111, 1'b0);
    expect_txn(1'b1, SS_EEP,  16'h0A00, 1'b1, 8, 16'h2222, 16'h2222, 1'b0);
    bus.ss0 = SS_AFE1; bus.data0 = 16'h2001;
    bus.ss1 = SS_EEP;  bus.data1 = 16'h0A00;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    wait_done(1'b0, 1'b1);
    wait_done(1'b1, 1'b1);
    repeat (GAP_CYC + 2) @(negedge clk);

    // Second simultaneous pair: last grant was 1, so 0 first again
    expect_txn(1'b0, SS_AFE2, 16'h3002, 1'b1, 5, 16'h3333, 16'h3333, 1'b0);
    expect_txn(1'b1, SS_EEP,  16'h0A02, 1'b1, 7, 16'h4444, 16'h4444, 1'b0);
    bus.ss0 = SS_AFE2; bus.data0 = 16'h3002; bus.data1 = 16'h0A02;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    wait_done(1'b0, 1'b1);
    wait_done(1'b1, 1'b1);
    repeat (GAP_CYC + 2) @(negedge clk);

    // Single AFE write
    expect_txn(1'b0, SS_AFE0, 16'h1328, 1'b1, 12, 16'h00A5, 16'h00A5, 1'b0);
    bus.ss0 = SS_AFE0; bus.data0 = 16'h1328; bus.req0 = 1'b1;
    wait_done(1'b0, 1'b1);
    repeat (GAP_CYC + 2) @(negedge clk);

    // req1 held continuously, req0 arrives during req1's BUSY
    expect_txn(1'b1, SS_EEP,  16'h0A10, 1'b1, 10, 16'h5501, 16'h5501, 1'b0);
    expect_txn(1'b0, SS_AFE1, 16'h1400, 1'b1, 5,  16'h5502, 16'h5502, 1'b0);
    expect_txn(1'b1, SS_EEP,  16'h0A10, 1'b1, 7,  16'h5503, 16'h5503, 1'b0);
    bus.ss1 = SS_EEP; bus.data1 = 16'h0A10; bus.req1 = 1'b1;
    wait_wrt();
    repeat (3) @(negedge clk);
    bus.ss0 = SS_AFE1; bus.data0 = 16'h1400; bus.req0 = 1'b1;
    wait_done(1'b1, 1'b0);
    wait_done(1'b0, 1'b1);
    wait_done(1'b1, 1'b1);
    repeat (GAP_CYC + 2) @(negedge clk);

    // SPI_done never returns: timeout, rd_data keeps last value
    expect_txn(1'b0, SS_EEP, 16'h8123, 1'b0, 0, 16'h0000, 16'h5503, 1'b1);
    bus.ss0 = SS_EEP; bus.data0 = 16'h8123; bus.req0 = 1'b1;
    wait_done(1'b0, 1'b1);
    repeat (GAP_CYC + 2) @(negedge clk);

    // Good transaction clears err
    expect_txn(1'b1, SS_EEP, 16'h0A20, 1'b1, 4, 16'h6060, 16'h6060, 1'b0);
    bus.data1 = 16'h0A20; bus.req1 = 1'b1;
    wait_done(1'b1, 1'b1);
    repeat (GAP_CYC + 2) @(negedge clk);

    // SPI_done one cycle too late lands in GAP: timeout, late done ignored
    expect_txn(1'b0, SS_AFE2, 16'h2B2B, 1'b1, TIMEOUT + 1, 16'h9999, 16'h6060, 1'b1);
    bus.ss0 = SS_AFE2; bus.data0 = 16'h2B2B; bus.req0 = 1'b1;
    wait_done(1'b0, 1'b1);
    repeat (GAP_CYC + 2) @(negedge clk);

    // SPI_done on the timer's last cycle wins over timeout
    expect_txn(1'b1, SS_EEP, 16'h2A2A, 1'b1, TIMEOUT, 16'h7171, 16'h7171, 1'b0);
    bus.data1 = 16'h2A2A; bus.req1 = 1'b1;
    wait_done(1'b1, 1'b1);
    repeat (GAP_CYC + 2) @(negedge clk);

    // Async reset during BUSY: no done for the aborted transaction
    expect_txn(1'b0, SS_AFE2, 16'h4444, 1'b1, 12, 16'hBEEF, 16'hBEEF, 1'b0);
    done_q.delete(done_q.size() - 1);
    bus.ss0 = SS_AFE2; bus.data0 = 16'h4444; bus.req0 = 1'b1;
    wait_wrt();
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    bus.req0 = 1'b0;
    #1;
    check("arst_ss", bus.ss, SS_NONE);
    check("arst_wrt", bus.wrt_SPI, 1'b0);
    check("arst_rd_data", bus.rd_data, 16'h0000);
    check("arst_err", bus.err, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check("arst_done0", bus.done0, 1'b0);
      check("arst_done1", bus.done1, 1'b0);
      check("arst_hold_ss", bus.ss, SS_NONE);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Fresh request after reset is served normally
    expect_txn(1'b0, SS_AFE0, 16'h1234, 1'b1, 3, 16'h0F0F, 16'h0F0F, 1'b0);
    bus.ss0 = SS_AFE0; bus.data0 = 16'h1234; bus.req0 = 1'b1;
    wait_done(1'b0, 1'b1);
    repeat (GAP_CYC + 3) @(negedge clk);

    check("launch_q_drained", launch_q.size(), 0);
    check("done_q_drained", done_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
